// File: rtl/alu_op_sequencer.sv
// Purpose: steps an ALU through 4 ops x 2 display modes (octal/Gray), holding each step DWELL_CYCLES cycles.
// Latency: SHOW starts on the edge that accepts Start_in, lasts 8*DWELL_CYCLES cycles, then a 1-cycle DONE.
// Backpressure: none; Start_in ignored while busy, Abort_in cancels. `SEQ_PAUSE_EN adds Pause_in to freeze SHOW.
module alu_op_sequencer #(
  parameter int DWELL_CYCLES = 8
) (
  input  logic       CLK_in,
  input  logic       RSTn_in,
  input  logic       Start_in,
  input  logic       Abort_in,
`ifdef SEQ_PAUSE_EN
  input  logic       Pause_in,
`endif
  input  logic [2:0] Num_A_in,
  input  logic [2:0] Num_B_in,
  output logic [2:0] Num_A_out,
  output logic [2:0] Num_B_out,
  output logic [1:0] Sel_A_out,
  output logic       Sel_M_out,
  output logic       Disp_on_out,
  output logic       Busy_out,
  output logic       Done_out
);

  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

  // Terminal value of the dwell counter; 8 bits covers the full 1..255 range.
  localparam logic [7:0] LAST_CNT = 8'(DWELL_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       hold;
  logic       step_end;
  logic       last_step;
  logic       accept;

`ifdef SEQ_PAUSE_EN
  assign hold = Pause_in;
`else
  assign hold = 1'b0;
`endif

  assign step_end  = (cnt == LAST_CNT);
  assign last_step = (Sel_A_out == 2'd3) && Sel_M_out;
  // Abort beats start when both arrive together in IDLE.
  assign accept    = (state == IDLE) && Start_in && !Abort_in;

  // Next-state decode; abort leaves SHOW even while paused, DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SHOW;
      SHOW: begin
        if (Abort_in) begin
          state_nxt = IDLE;
        end else if (!hold && step_end && last_step) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK_in) begin
    if (!RSTn_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture, dwell counter and step advance; sel/operands hold outside SHOW.
  always_ff @(posedge CLK_in) begin
    if (!RSTn_in) begin
      cnt       <= 8'd0;
      Sel_A_out <= 2'd0;
      Sel_M_out <= 1'b0;
      Num_A_out <= 3'd0;
      Num_B_out <= 3'd0;
    end else if (accept) begin
      cnt       <= 8'd0;
      Sel_A_out <= 2'd0;
      Sel_M_out <= 1'b0;
      Num_A_out <= Num_A_in;
      Num_B_out <= Num_B_in;
    end else if (state == SHOW && !Abort_in && !hold) begin
      if (step_end) begin
        cnt <= 8'd0;
        // {sel_a, sel_m} as one 3-bit count gives M toggling with A stepping on the 1->0 wrap.
        if (!last_step) begin
          {Sel_A_out, Sel_M_out} <= {Sel_A_out, Sel_M_out} + 3'd1;
        end
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Status outputs decoded straight from the state.
  always_comb begin
    Busy_out    = (state != IDLE);
    Disp_on_out = (state == SHOW);
    Done_out    = (state == DONE);
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboarded bench for alu_op_sequencer: three instances (dwell 2, 1, 5) share one stimulus stream.
// The reference model derives the step from elapsed SHOW cycles; a monitor compares every cycle.
module tb_alu_op_sequencer;

  localparam int NI = 3;

  typedef struct packed {
    logic [2:0] na;
    logic [2:0] nb;
    logic [1:0] sa;
    logic       sm;
    logic       disp;
    logic       busy;
    logic       done;
  } obs_t;

  typedef obs_t [NI-1:0] obs_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] a_in  = 3'd0;
  logic [2:0] b_in  = 3'd0;

  logic [2:0] na   [NI];
  logic [2:0] nb   [NI];
  logic [1:0] sa   [NI];
  logic       sm   [NI];
  logic       disp [NI];
  logic       busy [NI];
  logic       done [NI];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  obs_vec_t exp_q[$];

  // Reference model state: 0 idle, 1 showing, 2 done pulse.
  int   mode  [NI];
  int   t_el  [NI];
  obs_t m_out [NI];

  function automatic int dwell_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  alu_op_sequencer #(.DWELL_CYCLES(2)) u_dut0 (
    .CLK_in(clk), .RSTn_in(rst_n), .Start_in(start), .Abort_in(abort),
`ifdef SEQ_PAUSE_EN
    .Pause_in(pause),
`endif
    .Num_A_in(a_in), .Num_B_in(b_in),
    .Num_A_out(na[0]), .Num_B_out(nb[0]), .Sel_A_out(sa[0]), .Sel_M_out(sm[0]),
    .Disp_on_out(disp[0]), .Busy_out(busy[0]), .Done_out(done[0])
  );

  alu_op_sequencer #(.DWELL_CYCLES(1)) u_dut1 (
    .CLK_in(clk), .RSTn_in(rst_n), .Start_in(start), .Abort_in(abort),
`ifdef SEQ_PAUSE_EN
    .Pause_in(pause),
`endif
    .Num_A_in(a_in), .Num_B_in(b_in),
    .Num_A_out(na[1]), .Num_B_out(nb[1]), .Sel_A_out(sa[1]), .Sel_M_out(sm[1]),
    .Disp_on_out(disp[1]), .Busy_out(busy[1]), .Done_out(done[1])
  );

  alu_op_sequencer #(.DWELL_CYCLES(5)) u_dut2 (
    .CLK_in(clk), .RSTn_in(rst_n), .Start_in(start), .Abort_in(abort),
`ifdef SEQ_PAUSE_EN
    .Pause_in(pause),
`endif
    .Num_A_in(a_in), .Num_B_in(b_in),
    .Num_A_out(na[2]), .Num_B_out(nb[2]), .Sel_A_out(sa[2]), .Sel_M_out(sm[2]),
    .Disp_on_out(disp[2]), .Busy_out(busy[2]), .Done_out(done[2])
  );

  // Advance the model of instance i by one clock edge using the inputs now applied.
  task automatic model_step(input int i);
    int d;
    int step;
    d = dwell_of(i);
    if (!rst_n) begin
      mode[i]  = 0;
      t_el[i]  = 0;
      m_out[i] = '0;
    end else begin
      case (mode[i])
        0: begin
          if (start && !abort) begin
            mode[i]     = 1;
            t_el[i]     = 0;
            m_out[i].na = a_in;
            m_out[i].nb = b_in;
            m_out[i].sa = 2'd0;
            m_out[i].sm = 1'b0;
          end
        end
        1: begin
          if (abort) begin
            mode[i] = 0;
          end else if (!pause) begin
            t_el[i] = t_el[i] + 1;
            if (t_el[i] == 8 * d) begin
              mode[i] = 2;
            end else begin
              step        = t_el[i] / d;
              m_out[i].sa = 2'(step / 2);
              m_out[i].sm = 1'(step % 2);
            end
          end
        end
        default: mode[i] = 0;
      endcase
    end
    m_out[i].busy = (mode[i] != 0);
    m_out[i].disp = (mode[i] == 1);
    m_out[i].done = (mode[i] == 2);
  endtask

  // Apply one cycle of inputs and queue the outputs expected after the following rising edge.
  task automatic drive(input logic r, input logic s, input logic ab,
                       input logic [2:0] a, input logic [2:0] b, input logic p);
    obs_vec_t v;
    @(negedge clk);
    #1;
    rst_n = r; start = s; abort = ab; a_in = a; b_in = b; pause = p;
    for (int i = 0; i < NI; i++) begin
      model_step(i);
      v[i] = m_out[i];
    end
    exp_q.push_back(v);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  // Monitor: every cycle the DUTs present a full output vector; compare against the oldest expectation.
  initial begin
    forever begin
      obs_vec_t e;
      obs_t     g;
      @(negedge clk);
      cyc = cyc + 1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          g = {na[i], nb[i], sa[i], sm[i], disp[i], busy[i], done[i]};
          checks = checks + 1;
          if (g !== e[i]) begin
            errors = errors + 1;
            $display("FAIL outputs dwell=%0d cyc=%0d: got na=%0d nb=%0d sa=%0d sm=%0b disp=%0b busy=%0b done=%0b, required na=%0d nb=%0d sa=%0d sm=%0b disp=%0b busy=%0b done=%0b",
                     dwell_of(i), cyc, g.na, g.nb, g.sa, g.sm, g.disp, g.busy, g.done,
                     e[i].na, e[i].nb, e[i].sa, e[i].sm, e[i].disp, e[i].busy, e[i].done);
          end
        end
      end
    end
  end

  initial begin
    int drain;
    for (int i = 0; i < NI; i++) begin
      mode[i] = 0; t_el[i] = 0; m_out[i] = '0;
    end

    // Reset, then start on the very first released edge with A=5, B=3.
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b0, 3'd6, 3'd6, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 3'd5, 3'd3, 1'b0);
    idle_cycles(45);

    // Start held high with A changed mid-SHOW: operands stay, back-to-back restarts.
    for (int k = 0; k < 60; k++)
      drive(1'b1, 1'b1, 1'b0, (k < 5) ? 3'd7 : 3'd2, 3'd1, 1'b0);
    idle_cycles(45);

    // Abort while the dwell-2 instance shows step (1,1).
    drive(1'b1, 1'b1, 1'b0, 3'd4, 3'd2, 1'b0);
    idle_cycles(6);
    drive(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0);
    idle_cycles(4);

    // Reset during step (2,0), then start and abort together must not start.
    drive(1'b1, 1'b1, 1'b0, 3'd3, 3'd6, 1'b0);
    idle_cycles(8);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 1'b0);
    idle_cycles(3);

`ifdef SEQ_PAUSE_EN
    // Pause for 5 cycles mid-SHOW, then a pause overlapped by abort.
    drive(1'b1, 1'b1, 1'b0, 3'd5, 3'd3, 1'b0);
    idle_cycles(4);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1);
    idle_cycles(45);
    drive(1'b1, 1'b1, 1'b0, 3'd2, 3'd7, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1);
    idle_cycles(3);
`endif

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      logic r, s, ab, p;
      r  = ($urandom_range(0, 199) != 0);
      s  = ($urandom_range(0, 5) == 0);
      ab = ($urandom_range(0, 49) == 0);
`ifdef SEQ_PAUSE_EN
      p  = ($urandom_range(0, 5) == 0);
`else
      p  = 1'b0;
`endif
      drive(r, s, ab, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), p);
    end

    // Let the monitor consume the remaining expectations, bounded.
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain = drain + 1;
    end
    @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter DWELL_CYCLES, default 8: number of clock cycles each (operation, display-mode) step is held; legal range 1..255.
REQ-002 CLK_in  input  1  the single clock; all state updates on its rising edge.
REQ-003 RSTn_in  input  1  reset, synchronous and active-low.
REQ-004 Start_in  input  1  request to run one full sequence; sampled only in IDLE.
REQ-005 Abort_in  input  1  synchronous abort of the running sequence.
REQ-006 Num_A_in  input  3  operand A, captured on an accepted start.
REQ-007 Num_B_in  input  3  operand B, captured on an accepted start.
REQ-008 Num_A_out  output  3  latched operand A to the ALU.
REQ-009 Num_B_out  output  3  latched operand B to the ALU.
REQ-010 Sel_A_out  output  2  ALU operation select.
REQ-011 Sel_M_out  output  1  display mux select: 0 = octal, 1 = Gray.
REQ-012 Disp_on_out  output  1  display enable; 1 only while a step is shown.
REQ-013 Busy_out  output  1  high while a sequence is in progress.
REQ-014 Done_out  output  1  one-cycle pulse marking normal completion.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHOW and DONE.
REQ-016 IDLE outputs: Busy_out=0, Disp_on_out=0, Done_out=0; Sel_A_out, Sel_M_out, Num_A_out and Num_B_out hold their last values.
REQ-017 In IDLE, Start_in=1 with Abort_in=0 at edge k SHALL latch Num_A_in/Num_B_in, set Sel_A_out=0, Sel_M_out=0 and dwell counter=0, and enter SHOW, so Busy_out=1 and Disp_on_out=1 after edge k.
REQ-018 In SHOW the dwell counter SHALL increment every cycle. At count DWELL_CYCLES-1 it SHALL reset to 0 and advance the step.
REQ-019 Step order: Sel_M_out toggles 0->1; on the 1->0 wrap, Sel_A_out increments. Resulting sequence: (0,0),(0,1),(1,0),(1,1),(2,0),(2,1),(3,0),(3,1).
REQ-020 The terminal count of step (3,1) SHALL enter DONE instead of wrapping. SHOW therefore lasts exactly 8*DWELL_CYCLES cycles.
REQ-021 DONE SHALL last exactly one cycle: Done_out=1, Busy_out=1, Disp_on_out=0. The next state is IDLE.
REQ-022 Start_in SHALL be ignored in SHOW and DONE; operands SHALL NOT change after capture.
REQ-023 Abort_in=1 in SHOW SHALL force IDLE at the next edge with no Done_out pulse. Sel and operand outputs hold.
REQ-024 Abort_in in DONE SHALL be ignored; the Done_out pulse completes.
REQ-025 Start_in=1 and Abort_in=1 together in IDLE: abort wins and the FSM stays in IDLE.
REQ-026 A new Start_in in the first IDLE cycle after DONE SHALL be accepted, giving back-to-back sequences with one IDLE cycle between them.
REQ-027 When DWELL_CYCLES=1, each step SHALL last exactly one cycle.

Reset
REQ-028 RSTn_in=0 at a rising edge SHALL force IDLE, counter=0 and every output to 0, regardless of state (including mid-SHOW); reset has priority over Start_in and Abort_in.
REQ-029 The first Start_in SHALL be accepted on the first edge with RSTn_in=1.

Configuration
REQ-030 With macro SEQ_PAUSE_EN defined:
- input Pause_in (1 bit) exists.
- Pause_in=1 in SHOW freezes the dwell counter, step and all outputs.
- Abort_in and reset still act during pause.
REQ-031 Without SEQ_PAUSE_EN, Pause_in SHALL be absent and SHOW timing SHALL be exactly as in REQ-020.

Verification
REQ-032 DWELL_CYCLES=2: reset, then Start_in pulse with A=5, B=3 -> Num_A_out=5 and Num_B_out=3 for 16 cycles; (Sel_A_out,Sel_M_out) follows REQ-019 changing every 2 cycles; Done_out=1 on cycle 17 only; Busy_out=0 on cycle 18.
REQ-033 Start_in held high with A=7, B=1, and A changed to 2 mid-SHOW -> Num_A_out stays 7; exactly one Done_out; a second sequence starts on cycle 18.
REQ-034 Abort_in asserted during step (1,1) -> Busy_out=0 and Disp_on_out=0 after the next edge; Sel_A_out=1 and Sel_M_out=1 held; no Done_out.
REQ-035 RSTn_in=0 during step (2,0) -> all outputs 0 after that edge; Start_in and Abort_in both high in IDLE -> no start.
REQ-036 DWELL_CYCLES=1, Start_in -> 8 consecutive distinct steps, then Done_out on cycle 9.
REQ-037 SEQ_PAUSE_EN defined, Pause_in=1 for 5 cycles during SHOW -> outputs frozen; Done_out arrives 5 cycles later than in REQ-032.
